// File: rtl/body_integrator.sv
// body_integrator: semi-implicit Euler timestep over N bodies
// held in a shared 80-bit BRAM; each state word is updated in place.
module body_integrator #(
    parameter int          N          = 2,
    parameter logic [14:0] STATE_BASE = 15'h000,
    parameter logic [14:0] FORCE_BASE = 15'h190,
    parameter int          DT_SHIFT   = 4,
    parameter int          RD_LAT     = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [14:0] rd_addr,
    input  logic [79:0] rd_data,
    output logic [14:0] wr_addr,
    output logic [79:0] wr_data,
    output logic        wr_en
);
    localparam logic [9:0]  LAST_IDX  = 10'(N - 1);
    localparam logic [15:0] WAIT_LAST = 16'(RD_LAT - 2);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_S, S_RD_F, S_WAIT, S_CALC, S_WR, S_DONE
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [9:0]  r_idx;
    logic [15:0] r_wcnt;
    logic [14:0] r_rd_addr, r_wr_addr;
    logic [79:0] r_sword, r_wr_data;
    logic        w_cap_s, w_last, w_unused;

    logic signed [19:0] w_px, w_py, w_vx, w_vy, w_fx, w_fy;
    logic signed [19:0] w_fxs, w_fys, w_vxn, w_vyn;
    logic signed [19:0] w_vxs, w_vys, w_pxn, w_pyn;

    function automatic logic signed [19:0] sat20(input logic signed [20:0] a);
        if (a > 21'sd524287) return 20'sh7FFFF;
        else if (a < -21'sd524288) return 20'sh80000;
        return a[19:0];
    endfunction

    assign w_px = r_sword[79:60];
    assign w_py = r_sword[59:40];
    assign w_vx = r_sword[39:20];
    assign w_vy = r_sword[19:0];
    assign w_fx = {{4{rd_data[31]}}, rd_data[31:16]};
    assign w_fy = {{4{rd_data[15]}}, rd_data[15:0]};
    // Upper force-word bits carry no information for this stage.
    assign w_unused = ^rd_data[79:32];

    assign w_fxs = w_fx >>> DT_SHIFT;
    assign w_fys = w_fy >>> DT_SHIFT;
    assign w_vxn = sat20({w_vx[19], w_vx} + {w_fxs[19], w_fxs});
    assign w_vyn = sat20({w_vy[19], w_vy} + {w_fys[19], w_fys});
    // Position integrates the already-updated velocity.
    assign w_vxs = w_vxn >>> DT_SHIFT;
    assign w_vys = w_vyn >>> DT_SHIFT;
    assign w_pxn = sat20({w_px[19], w_px} + {w_vxs[19], w_vxs});
    assign w_pyn = sat20({w_py[19], w_py} + {w_vys[19], w_vys});

    assign w_last  = (r_idx == LAST_IDX);
    assign w_cap_s = (RD_LAT == 1) ? (r_state == S_RD_F)
                   : (r_state == S_WAIT && r_wcnt == WAIT_LAST);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state and strobe decode
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        wr_en       = 1'b0;
        unique case (r_state)
            S_IDLE: if (start) w_state_nxt = S_RD_S;
            S_RD_S: begin
                busy        = 1'b1;
                w_state_nxt = S_RD_F;
            end
            S_RD_F: begin
                busy        = 1'b1;
                w_state_nxt = (RD_LAT == 1) ? S_CALC : S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (r_wcnt == WAIT_LAST) w_state_nxt = S_CALC;
            end
            S_CALC: begin
                busy        = 1'b1;
                w_state_nxt = S_WR;
            end
            S_WR: begin
                busy        = 1'b1;
                wr_en       = 1'b1;
                w_state_nxt = w_last ? S_DONE : S_RD_S;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Body index, read address, word captures and write-back registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx     <= '0;
            r_wcnt    <= '0;
            r_rd_addr <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_sword   <= '0;
        end else begin
            if (r_state == S_WAIT) r_wcnt <= r_wcnt + 16'd1;
            else                   r_wcnt <= '0;
            if (r_state == S_IDLE && start) begin
                r_idx     <= '0;
                r_rd_addr <= STATE_BASE;
            end else if (r_state == S_RD_S) begin
                r_rd_addr <= FORCE_BASE + {5'd0, r_idx};
            end else if (r_state == S_WR && !w_last) begin
                r_idx     <= r_idx + 10'd1;
                r_rd_addr <= STATE_BASE + {5'd0, r_idx} + 15'd1;
            end
            if (w_cap_s) r_sword <= rd_data;
            if (r_state == S_CALC) begin
                r_wr_data <= {w_pxn, w_pyn, w_vxn, w_vyn};
                r_wr_addr <= STATE_BASE + {5'd0, r_idx};
            end
        end
    end

    assign rd_addr = r_rd_addr;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
endmodule

// File: tb/tb_body_integrator.sv
// tb_body_integrator: scoreboard bench for body_integrator,
// two instances (N=5/DT=4/RD_LAT=2 and N=1/DT=0/RD_LAT=1).
module tb_body_integrator;
    localparam logic [14:0] SB0 = 15'h000;
    localparam logic [14:0] FB0 = 15'h190;
    localparam logic [14:0] SB1 = 15'h008;
    localparam logic [14:0] FB1 = 15'h040;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, start0, start1;
    logic        busy0, done0, wr_en0, busy1, done1, wr_en1;
    logic [14:0] rd_addr0, wr_addr0, rd_addr1, wr_addr1;
    logic [79:0] rd_data0, wr_data0, rd_data1, wr_data1;

    body_integrator #(
        .N(5), .STATE_BASE(SB0), .FORCE_BASE(FB0),
        .DT_SHIFT(4), .RD_LAT(2)
    ) u_dut0 (
        .clk(clk), .reset_n(reset_n), .start(start0),
        .busy(busy0), .done(done0),
        .rd_addr(rd_addr0), .rd_data(rd_data0),
        .wr_addr(wr_addr0), .wr_data(wr_data0), .wr_en(wr_en0)
    );

    body_integrator #(
        .N(1), .STATE_BASE(SB1), .FORCE_BASE(FB1),
        .DT_SHIFT(0), .RD_LAT(1)
    ) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1),
        .busy(busy1), .done(done1),
        .rd_addr(rd_addr1), .rd_data(rd_data1),
        .wr_addr(wr_addr1), .wr_data(wr_data1), .wr_en(wr_en1)
    );

    // BRAM models with a bench-side load port
    logic [79:0] mem0 [0:511];
    logic [79:0] mem1 [0:511];
    logic        ld_en = 1'b0, ld_sel = 1'b0;
    logic [8:0]  ld_addr = '0;
    logic [79:0] ld_data = '0;
    logic [8:0]  ra0a, ra0b, ra1a;

    always @(posedge clk) begin
        ra0a <= rd_addr0[8:0];
        ra0b <= ra0a;
        ra1a <= rd_addr1[8:0];
        if (ld_en && !ld_sel) mem0[ld_addr] <= ld_data;
        else if (wr_en0)      mem0[wr_addr0[8:0]] <= wr_data0;
        if (ld_en && ld_sel)  mem1[ld_addr] <= ld_data;
        else if (wr_en1)      mem1[wr_addr1[8:0]] <= wr_data1;
    end
    assign rd_data0 = mem0[ra0b];
    assign rd_data1 = mem1[ra1a];

    int n_tests = 0;
    int n_fail  = 0;
    logic [94:0] exp_q [$];
    logic [79:0] s [5];
    logic [79:0] f [5];

    function automatic int sat(input int a);
        if (a > 524287) return 524287;
        if (a < -524288) return -524288;
        return a;
    endfunction

    function automatic logic [79:0] euler(input logic [79:0] st,
                                          input logic [79:0] fw,
                                          input int dt);
        int px, py, vx, vy, fx, fy;
        px = int'($signed(st[79:60]));
        py = int'($signed(st[59:40]));
        vx = int'($signed(st[39:20]));
        vy = int'($signed(st[19:0]));
        fx = int'($signed(fw[31:16]));
        fy = int'($signed(fw[15:0]));
        vx = sat(vx + (fx >>> dt));
        vy = sat(vy + (fy >>> dt));
        px = sat(px + (vx >>> dt));
        py = sat(py + (vy >>> dt));
        return {px[19:0], py[19:0], vx[19:0], vy[19:0]};
    endfunction

    task automatic load(input logic sel, input logic [8:0] a,
                        input logic [79:0] d);
        ld_sel  = sel;
        ld_addr = a;
        ld_data = d;
        ld_en   = 1'b1;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start0  = 1'b0;
        start1  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({busy0, done0, wr_en0} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctl0: got %b want 000",
                     {busy0, done0, wr_en0});
        end
        n_tests++;
        if ({rd_addr0, wr_addr0} !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_addr0: got %h want 0",
                     {rd_addr0, wr_addr0});
        end
        n_tests++;
        if (wr_data0 !== 80'd0) begin
            n_fail++;
            $display("FAIL reset_wdata0: got %h want 0", wr_data0);
        end
        n_tests++;
        if ({busy1, done1, wr_en1, rd_addr1} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_dut1: got %h want 0",
                     {busy1, done1, wr_en1, rd_addr1});
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        logic [79:0] st, fw;
        logic [94:0] e;
        int nw, nd;
        st = {20'd10, 20'(-5), 20'd1, 20'd2};
        fw = {48'hDEAD_BEEF_0123, 16'd3, 16'(-4)};
        load(1'b1, SB1[8:0], st);
        load(1'b1, FB1[8:0], fw);
        exp_q.push_back({SB1, 20'd14, 20'(-7), 20'd4, 20'(-2)});
        nw = 0;
        nd = 0;
        start1 = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            start1 = 1'b0;
            if (c == 1) begin
                n_tests++;
                if ({busy1, rd_addr1} !== {1'b1, SB1}) begin
                    n_fail++;
                    $display("FAIL single_rds: got %h want %h",
                             {busy1, rd_addr1}, {1'b1, SB1});
                end
            end
            if (c == 2) begin
                n_tests++;
                if (rd_addr1 !== FB1) begin
                    n_fail++;
                    $display("FAIL single_rdf: got %h want %h",
                             rd_addr1, FB1);
                end
            end
            if (wr_en1) begin
                nw++;
                n_tests++;
                if (c != 4) begin
                    n_fail++;
                    $display("FAIL single_wr_cyc: got %0d want 4", c);
                end
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL single_extra_wr: got %h want none",
                             wr_data1);
                end else begin
                    e = exp_q.pop_front();
                    if ({wr_addr1, wr_data1} !== e) begin
                        n_fail++;
                        $display("FAIL single_wr: got %h want %h",
                                 {wr_addr1, wr_data1}, e);
                    end
                end
            end
            if (done1) begin
                nd++;
                n_tests++;
                if (c != 5 || busy1 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_done: got cyc %0d busy %b want 5 0",
                             c, busy1);
                end
            end
        end
        n_tests++;
        if (nw != 1 || nd != 1 || mem1[FB1[8:0]] !== fw) begin
            n_fail++;
            $display("FAIL single_count: got %0d wr %0d done want 1 1",
                     nw, nd);
        end
        exp_q.delete();
    endtask

    task automatic test_multi();
        logic [94:0] e;
        int nw, nd;
        logic fok;
        s[0] = '0;
        f[0] = {48'd0, 16'(-32), 16'd17};
        s[1] = {20'd520000, 20'd0, 20'h7FFFF, 20'd100};
        f[1] = {48'hFFFF_FFFF_FFFF, 16'h7FFF, 16'(-16)};
        s[2] = {20'(-520000), 20'd0, 20'h80000, 20'(-100)};
        f[2] = {48'h1234_5678_9ABC, 16'h8000, 16'd16};
        for (int i = 3; i < 5; i++) begin
            s[i] = {16'($urandom), $urandom, $urandom};
            f[i] = {16'($urandom), $urandom, $urandom};
        end
        for (int i = 0; i < 5; i++) begin
            load(1'b0, 9'(SB0 + 15'(i)), s[i]);
            load(1'b0, 9'(FB0 + 15'(i)), f[i]);
        end
        exp_q.push_back({SB0, 20'(-1), 20'd0, 20'(-2), 20'd1});
        exp_q.push_back({SB0 + 15'd1, 20'h7FFFF, 20'd6,
                         20'h7FFFF, 20'd99});
        exp_q.push_back({SB0 + 15'd2, 20'h80000, 20'(-7),
                         20'h80000, 20'(-99)});
        for (int i = 3; i < 5; i++)
            exp_q.push_back({SB0 + 15'(i), euler(s[i], f[i], 4)});
        nw = 0;
        nd = 0;
        start0 = 1'b1;
        for (int c = 1; c <= 35; c++) begin
            @(posedge clk); #1;
            start0 = 1'b0;
            if (c == 1) begin
                n_tests++;
                if (busy0 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL multi_busy: got %b want 1", busy0);
                end
            end
            if (wr_en0) begin
                n_tests++;
                if (c != 5 + 5 * nw) begin
                    n_fail++;
                    $display("FAIL multi_wr_cyc: got %0d want %0d",
                             c, 5 + 5 * nw);
                end
                nw++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL multi_extra_wr: got %h want none",
                             wr_data0);
                end else begin
                    e = exp_q.pop_front();
                    if ({wr_addr0, wr_data0} !== e) begin
                        n_fail++;
                        $display("FAIL multi_wr: got %h want %h",
                                 {wr_addr0, wr_data0}, e);
                    end
                end
            end
            if (done0) begin
                nd++;
                n_tests++;
                if (c != 26 || busy0 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL multi_done: got cyc %0d busy %b want 26 0",
                             c, busy0);
                end
            end
        end
        fok = 1'b1;
        for (int i = 0; i < 5; i++)
            if (mem0[9'(FB0 + 15'(i))] !== f[i]) fok = 1'b0;
        n_tests++;
        if (nw != 5 || nd != 1 || !fok || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL multi_count: got %0d wr %0d done fok %b want 5 1 1",
                     nw, nd, fok);
        end
        exp_q.delete();
        for (int i = 0; i < 5; i++) s[i] = euler(s[i], f[i], 4);
    endtask

    task automatic test_start_ignored();
        logic [94:0] e;
        int nw, nd;
        logic late_busy;
        for (int i = 0; i < 5; i++)
            exp_q.push_back({SB0 + 15'(i), euler(s[i], f[i], 4)});
        nw = 0;
        nd = 0;
        late_busy = 1'b0;
        start0 = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            start0 = (c == 3 || c == 8 || c == 26);
            if (c > 26 && (busy0 || wr_en0)) late_busy = 1'b1;
            if (wr_en0) begin
                nw++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL ign_extra_wr: got %h want none",
                             wr_data0);
                end else begin
                    e = exp_q.pop_front();
                    if ({wr_addr0, wr_data0} !== e) begin
                        n_fail++;
                        $display("FAIL ign_wr: got %h want %h",
                                 {wr_addr0, wr_data0}, e);
                    end
                end
            end
            if (done0) nd++;
        end
        n_tests++;
        if (nw != 5 || nd != 1) begin
            n_fail++;
            $display("FAIL ign_count: got %0d wr %0d done want 5 1",
                     nw, nd);
        end
        n_tests++;
        if (late_busy) begin
            n_fail++;
            $display("FAIL ign_restart: got busy after done want idle");
        end
        exp_q.delete();
        for (int i = 0; i < 5; i++) s[i] = euler(s[i], f[i], 4);
    endtask

    task automatic test_reset_mid();
        logic [94:0] e;
        int nw, nd;
        logic bad, tok;
        for (int i = 0; i < 2; i++)
            exp_q.push_back({SB0 + 15'(i), euler(s[i], f[i], 4)});
        nw = 0;
        start0 = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            start0 = 1'b0;
            if (wr_en0) begin
                nw++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rst_extra_wr: got %h want none",
                             wr_data0);
                end else begin
                    e = exp_q.pop_front();
                    if ({wr_addr0, wr_data0} !== e) begin
                        n_fail++;
                        $display("FAIL rst_wr: got %h want %h",
                                 {wr_addr0, wr_data0}, e);
                    end
                end
            end
        end
        n_tests++;
        if (rd_addr0 !== FB0 + 15'd2) begin
            n_fail++;
            $display("FAIL rst_in_rdf: got %h want %h",
                     rd_addr0, FB0 + 15'd2);
        end
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({wr_en0, busy0, done0, rd_addr0} !== 18'd0) begin
            n_fail++;
            $display("FAIL rst_async: got %h want 0",
                     {wr_en0, busy0, done0, rd_addr0});
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (wr_en0 || busy0 || done0) bad = 1'b1;
        end
        n_tests++;
        if (bad || nw != 2 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rst_quiet: got bad %b wr %0d want 0 2",
                     bad, nw);
        end
        tok = 1'b1;
        for (int i = 2; i < 5; i++)
            if (mem0[9'(SB0 + 15'(i))] !== s[i]) tok = 1'b0;
        n_tests++;
        if (!tok) begin
            n_fail++;
            $display("FAIL rst_untouched: got changed want bodies 2-4 intact");
        end
        exp_q.delete();
        for (int i = 0; i < 2; i++) s[i] = euler(s[i], f[i], 4);
        for (int i = 0; i < 5; i++)
            exp_q.push_back({SB0 + 15'(i), euler(s[i], f[i], 4)});
        nw = 0;
        nd = 0;
        start0 = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            start0 = 1'b0;
            if (wr_en0) begin
                nw++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL fresh_extra_wr: got %h want none",
                             wr_data0);
                end else begin
                    e = exp_q.pop_front();
                    if ({wr_addr0, wr_data0} !== e) begin
                        n_fail++;
                        $display("FAIL fresh_wr: got %h want %h",
                                 {wr_addr0, wr_data0}, e);
                    end
                end
            end
            if (done0) begin
                nd++;
                n_tests++;
                if (c != 26) begin
                    n_fail++;
                    $display("FAIL fresh_done: got %0d want 26", c);
                end
            end
        end
        n_tests++;
        if (nw != 5 || nd != 1) begin
            n_fail++;
            $display("FAIL fresh_count: got %0d wr %0d done want 5 1",
                     nw, nd);
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_start_ignored();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
